// File: rtl/layer_controller_pkg.sv
// Shared definitions for the layer controller: FSM state encoding and default widths.
package layer_controller_pkg;

  localparam int FCW_DEF     = 4;
  localparam int DEPTH_W_DEF = 3;
  localparam int ADDR_W_DEF  = 16;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_FETCH_W    = 3'd1,
    S_RUN        = 3'd2,
    S_WRITE_BACK = 3'd3,
    S_NEXT       = 3'd4,
    S_DONE       = 3'd5
  } state_e;

endpackage

// File: rtl/layer_controller_addr_stepper.sv
// Address accumulator: loads a base address, then adds a stride per step (wraps modulo 2^ADDR_W).
module addr_stepper
  import layer_controller_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              resetState,
  input  logic              load,
  input  logic [ADDR_W-1:0] base,
  input  logic              step,
  input  logic [ADDR_W-1:0] stride,
  output logic [ADDR_W-1:0] addr
);

  logic [ADDR_W-1:0] addr_q;

  always_ff @(posedge clk or negedge resetState) begin
    if (!resetState) begin
      addr_q <= '0;
    end else if (load) begin
      addr_q <= base;
    end else if (step) begin
      addr_q <= addr_q + stride;
    end
  end

  assign addr = addr_q;

endmodule

// File: rtl/layer_controller.sv
// Sequences one conv layer: per filter fetch weights, run the filter controller, write back.
// Handshakes: dmaReq/wbReq are level requests held until their done strobe is seen in the
// owning state; done strobes arriving in any other state are ignored.
module layer_controller
  import layer_controller_pkg::*;
#(
  parameter int FILTER_CNT_W = FCW_DEF,
  parameter int DEPTH_W      = DEPTH_W_DEF,
  parameter int ADDR_W       = ADDR_W_DEF
) (
  input  logic                    clk,
  input  logic                    resetState,
  input  logic                    start,
  input  logic [FILTER_CNT_W-1:0] numFilters,
  input  logic [DEPTH_W-1:0]      depth,
  input  logic [ADDR_W-1:0]       wBase,
  input  logic [ADDR_W-1:0]       wStride,
  input  logic [ADDR_W-1:0]       oBase,
  input  logic [ADDR_W-1:0]       oStride,
  output logic                    dmaReq,
  output logic [ADDR_W-1:0]       dmaAddr,
  input  logic                    dmaFinish,
  output logic                    filterStart,
  output logic [DEPTH_W-1:0]      filterDepth,
  input  logic                    filterDone,
  output logic                    wbReq,
  output logic [ADDR_W-1:0]       wbAddr,
  input  logic                    wbDone,
  output logic [FILTER_CNT_W-1:0] filterIdx,
  output logic                    busy,
  output logic                    layerDone,
  output logic [2:0]              dbgState
);

  state_e                  state_q, state_d;
  logic [FILTER_CNT_W-1:0] num_filters_q, idx_q;
  logic [DEPTH_W-1:0]      depth_q;
  logic [ADDR_W-1:0]       w_stride_q, o_stride_q;
  logic                    dma_req_q, filter_start_q, wb_req_q, busy_q, layer_done_q;
  logic                    accept, step, last_filter;

  assign accept      = (state_q == S_IDLE) && start;
  assign step        = (state_d == S_NEXT);
  assign last_filter = (idx_q == num_filters_q - FILTER_CNT_W'(1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:       if (start) state_d = (numFilters == '0) ? S_DONE : S_FETCH_W;
      S_FETCH_W:    if (dmaFinish) state_d = S_RUN;
      // filter_start_q marks the first RUN cycle, where filterDone is not yet meaningful
      S_RUN:        if (filterDone && !filter_start_q) state_d = S_WRITE_BACK;
      S_WRITE_BACK: if (wbDone) state_d = last_filter ? S_DONE : S_NEXT;
      S_NEXT:       state_d = S_FETCH_W;
      S_DONE:       state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state entry.
  always_ff @(posedge clk or negedge resetState) begin
    if (!resetState) begin
      state_q        <= S_IDLE;
      num_filters_q  <= '0;
      idx_q          <= '0;
      depth_q        <= '0;
      w_stride_q     <= '0;
      o_stride_q     <= '0;
      dma_req_q      <= 1'b0;
      filter_start_q <= 1'b0;
      wb_req_q       <= 1'b0;
      busy_q         <= 1'b0;
      layer_done_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      dma_req_q      <= (state_d == S_FETCH_W);
      filter_start_q <= (state_d == S_RUN) && (state_q != S_RUN);
      wb_req_q       <= (state_d == S_WRITE_BACK);
      busy_q         <= (state_d != S_IDLE);
      layer_done_q   <= (state_d == S_DONE);
      if (accept) begin
        num_filters_q <= numFilters;
        depth_q       <= depth;
        w_stride_q    <= wStride;
        o_stride_q    <= oStride;
        idx_q         <= '0;
      end else if (step) begin
        idx_q <= idx_q + FILTER_CNT_W'(1);
      end
    end
  end

  addr_stepper #(.ADDR_W(ADDR_W)) u_w_addr (
    .clk        (clk),
    .resetState (resetState),
    .load       (accept),
    .base       (wBase),
    .step       (step),
    .stride     (w_stride_q),
    .addr       (dmaAddr)
  );

  addr_stepper #(.ADDR_W(ADDR_W)) u_o_addr (
    .clk        (clk),
    .resetState (resetState),
    .load       (accept),
    .base       (oBase),
    .step       (step),
    .stride     (o_stride_q),
    .addr       (wbAddr)
  );

  assign dmaReq      = dma_req_q;
  assign filterStart = filter_start_q;
  assign filterDepth = depth_q;
  assign wbReq       = wb_req_q;
  assign filterIdx   = idx_q;
  assign busy        = busy_q;
  assign layerDone   = layer_done_q;
  assign dbgState    = state_q;

endmodule

// File: tb/tb_layer_controller.sv
// Directed bench for layer_controller: fixed-latency handshake responder, addresses from a
// multiply-based reference model, layerDone pulses counted independently of the sequencing.
module tb_layer_controller;
  import layer_controller_pkg::*;

  logic        clk = 1'b0;
  logic        resetState = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  numFilters = '0;
  logic [2:0]  depth = '0;
  logic [15:0] wBase = '0, wStride = '0, oBase = '0, oStride = '0;
  logic        dmaFinish = 1'b0, filterDone = 1'b0, wbDone = 1'b0;
  logic        dmaReq, filterStart, wbReq, busy, layerDone;
  logic [15:0] dmaAddr, wbAddr;
  logic [2:0]  filterDepth, dbgState;
  logic [3:0]  filterIdx;

  int checks = 0;
  int errors = 0;
  int ld_count = 0;
  int ld_before;
  logic [15:0] exp_q[$];
  logic [15:0] cur_ob, cur_os;

  layer_controller dut (
    .clk         (clk),
    .resetState  (resetState),
    .start       (start),
    .numFilters  (numFilters),
    .depth       (depth),
    .wBase       (wBase),
    .wStride     (wStride),
    .oBase       (oBase),
    .oStride     (oStride),
    .dmaReq      (dmaReq),
    .dmaAddr     (dmaAddr),
    .dmaFinish   (dmaFinish),
    .filterStart (filterStart),
    .filterDepth (filterDepth),
    .filterDone  (filterDone),
    .wbReq       (wbReq),
    .wbAddr      (wbAddr),
    .wbDone      (wbDone),
    .filterIdx   (filterIdx),
    .busy        (busy),
    .layerDone   (layerDone),
    .dbgState    (dbgState)
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(negedge clk) if (layerDone === 1'b1) ld_count++;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: expected weight addresses by multiplication, mod 2^16.
  task automatic load_model(input int nf, input logic [15:0] wb, input logic [15:0] ws);
    exp_q.delete();
    for (int i = 0; i < nf; i++) exp_q.push_back(16'(wb + 16'(i) * ws));
  endtask

  // Accepts a layer, then scrambles the config inputs to prove they were latched.
  task automatic start_layer(input logic [3:0] nf, input logic [2:0] d,
                             input logic [15:0] wb, input logic [15:0] ws,
                             input logic [15:0] ob, input logic [15:0] os);
    numFilters = nf; depth = d; wBase = wb; wStride = ws; oBase = ob; oStride = os;
    cur_ob = ob; cur_os = os;
    load_model(int'(nf), wb, ws);
    start = 1'b1;
    tick();
    start = 1'b0;
    numFilters = 4'($urandom_range(0, 15));
    depth      = 3'($urandom_range(0, 7));
    wBase      = 16'($urandom_range(0, 65535));
    wStride    = 16'($urandom_range(0, 65535));
    oBase      = 16'($urandom_range(0, 65535));
    oStride    = 16'($urandom_range(0, 65535));
    check("busy_after_start", busy, 1);
    check("filter_depth", filterDepth, d);
  endtask

  // Entered in the first FETCH_W cycle; leaves in the first cycle of NEXT+1 (FETCH_W) or idle.
  task automatic filter_cycle(input int idx, input logic last, input int dma_wait,
                              input logic early_fd, input logic poke_start);
    logic [15:0] exp_w, exp_o;
    exp_w = exp_q.pop_front();
    exp_o = 16'(cur_ob + 16'(idx) * cur_os);
    check("dma_req", dmaReq, 1);
    check("dma_addr", dmaAddr, exp_w);
    check("filter_idx", filterIdx, idx);
    for (int k = 0; k < dma_wait; k++) begin
      filterDone = 1'b1; wbDone = 1'b1;   // stray strobes while fetching
      tick();
      filterDone = 1'b0; wbDone = 1'b0;
      check("dma_req_held", dmaReq, 1);
      check("state_fetch", dbgState, S_FETCH_W);
    end
    dmaFinish = 1'b1;
    tick();
    dmaFinish = 1'b0;
    check("dma_req_drop", dmaReq, 0);
    check("filter_start", filterStart, 1);
    if (poke_start) begin
      start = 1'b1; numFilters = 4'd1; wBase = 16'hAAAA;
    end
    filterDone = early_fd;
    tick();
    start = 1'b0;
    check("filter_start_pulse", filterStart, 0);
    check("state_run_second", dbgState, S_RUN);
    check("no_wb_yet", wbReq, 0);
    check("idx_stable", filterIdx, idx);
    check("dma_addr_stable", dmaAddr, exp_w);
    filterDone = 1'b1;
    tick();
    filterDone = 1'b0;
    check("wb_req", wbReq, 1);
    check("wb_addr", wbAddr, exp_o);
    wbDone = 1'b1;
    tick();
    wbDone = 1'b0;
    check("wb_req_drop", wbReq, 0);
    if (last) begin
      check("layer_done", layerDone, 1);
      check("busy_in_done", busy, 1);
      tick();
      check("layer_done_pulse", layerDone, 0);
      check("idle_busy", busy, 0);
    end else begin
      check("next_no_done", layerDone, 0);
      check("next_idx", filterIdx, idx + 1);
      tick();
    end
  endtask

  initial begin
    #2 resetState = 1'b0;
    #3;
    check("rst_busy", busy, 0);
    check("rst_dma_req", dmaReq, 0);
    check("rst_wb_req", wbReq, 0);
    check("rst_idx", filterIdx, 0);
    check("rst_dma_addr", dmaAddr, 0);
    check("rst_state", dbgState, S_IDLE);
    @(negedge clk);
    resetState = 1'b1;
    tick();

    // 1: three filters, plain handshakes with DMA latency
    ld_before = ld_count;
    start_layer(4'd3, 3'd5, 16'h0100, 16'h0040, 16'h8000, 16'h0010);
    for (int i = 0; i < 3; i++) filter_cycle(i, i == 2, 2, 1'b0, 1'b0);
    check("t1_layer_done_count", ld_count - ld_before, 1);

    // 2: zero filters goes straight to DONE in the cycle after acceptance
    ld_before = ld_count;
    numFilters = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    check("t2_layer_done", layerDone, 1);
    check("t2_busy", busy, 1);
    check("t2_no_dma", dmaReq, 0);
    check("t2_no_fs", filterStart, 0);
    check("t2_no_wb", wbReq, 0);
    tick();
    check("t2_idle", busy, 0);
    check("t2_count", ld_count - ld_before, 1);

    // 3: start pulsed during RUN is ignored
    ld_before = ld_count;
    start_layer(4'd2, 3'd2, 16'h1000, 16'h0100, 16'h2000, 16'h0004);
    filter_cycle(0, 1'b0, 0, 1'b0, 1'b1);
    filter_cycle(1, 1'b1, 0, 1'b0, 1'b0);
    check("t3_count", ld_count - ld_before, 1);

    // 4: filterDone held from the filterStart cycle
    ld_before = ld_count;
    start_layer(4'd1, 3'd7, 16'h0300, 16'h0000, 16'h0400, 16'h0000);
    filter_cycle(0, 1'b1, 1, 1'b1, 1'b0);
    check("t4_count", ld_count - ld_before, 1);

    // 5: weight address wraps at 2^16
    start_layer(4'd2, 3'd1, 16'hFFE0, 16'h0020, 16'hFFFF, 16'h0001);
    check("t5_model_wrap", exp_q[1], 16'h0000);
    filter_cycle(0, 1'b0, 0, 1'b0, 1'b0);
    filter_cycle(1, 1'b1, 0, 1'b0, 1'b0);

    // 6: reset during WRITE_BACK, then a clean new layer
    ld_before = ld_count;
    start_layer(4'd2, 3'd3, 16'h0500, 16'h0010, 16'h0600, 16'h0020);
    filter_cycle(0, 1'b0, 0, 1'b0, 1'b0);
    dmaFinish = 1'b1;
    tick();
    dmaFinish = 1'b0;
    tick();
    filterDone = 1'b1;
    tick();
    filterDone = 1'b0;
    check("t6_in_wb", wbReq, 1);
    check("t6_idx_before", filterIdx, 1);
    #2 resetState = 1'b0;
    #1;
    check("t6_wb_req_async", wbReq, 0);
    check("t6_busy_async", busy, 0);
    check("t6_idx_async", filterIdx, 0);
    #1 resetState = 1'b1;
    tick();
    check("t6_no_layer_done", ld_count - ld_before, 0);
    start_layer(4'd1, 3'd4, 16'h0700, 16'h0008, 16'h0900, 16'h0002);
    filter_cycle(0, 1'b1, 1, 1'b0, 1'b0);
    check("t6_count", ld_count - ld_before, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
